// File: rtl/host_byte_sender.sv
// ---------------------------------------------------------------------------
// host_byte_sender
//
// Carries bytes from the host to the external Arduino. Bytes written by the
// host through active_transfer arrive as single-cycle pulses. They are held in
// a small FIFO and then presented on a parallel bus with a four-phase
// strobe/ack handshake:
//   data -> (setup) -> strobe high -> ack high -> strobe low -> ack low
// If the device fails to respond in time, the handshake is aborted and a
// sticky timeout flag is raised.
//
// Optional build macro:
//   HOST_SENDER_PARITY_EN : adds DEV_PARITY, which is the odd parity (XNOR of
//                           all bits) of DEV_DATA and is registered with it.
//
// Parameters:
//   FIFO_AW        log2 of the FIFO depth
//   SETUP_CYCLES   cycles DEV_DATA is held stable before DEV_STROBE rises (1..15)
//   TIMEOUT_CYCLES maximum cycles spent in STROBE or RELEASE before an abort
//
// Ports:
//   CLK                  system clock
//   RST                  asynchronous active-low reset
//   TRANSFER_IN_RECEIVED one-cycle pulse; TRANSFER_IN_BYTE is valid
//   TRANSFER_IN_BYTE     byte from the host
//   ENABLE               allows the FSM to start new transfers
//   CLEAR_ERR            one-cycle pulse; clears OVERFLOW and TIMEOUT_ERR
//   DEV_ACK              asynchronous acknowledge from the device
//   DEV_DATA             byte presented to the device
//   DEV_STROBE           data-valid strobe to the device
//   DEV_PARITY           (optional) odd parity of DEV_DATA
//   FIFO_EMPTY           FIFO holds no bytes
//   FIFO_FULL            FIFO holds 2^FIFO_AW bytes
//   BUSY                 a handshake is in progress
//   OVERFLOW             sticky: a byte was dropped because the FIFO was full
//   TIMEOUT_ERR          sticky: a handshake was aborted
// ---------------------------------------------------------------------------
module host_byte_sender #(
  parameter int FIFO_AW        = 2,
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TRANSFER_IN_RECEIVED,
  input  logic [7:0] TRANSFER_IN_BYTE,
  input  logic       ENABLE,
  input  logic       CLEAR_ERR,
  input  logic       DEV_ACK,
  output logic [7:0] DEV_DATA,
  output logic       DEV_STROBE,
`ifdef HOST_SENDER_PARITY_EN
  output logic       DEV_PARITY,
`endif
  output logic       FIFO_EMPTY,
  output logic       FIFO_FULL,
  output logic       BUSY,
  output logic       OVERFLOW,
  output logic       TIMEOUT_ERR
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = 12;

  localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [CW-1:0]      TICK_ONE   = CW'(1);
  localparam logic [CW-1:0]      SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0]      TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE
  } state_t;

  // -------------------------------------------------------------------------
  // Acknowledge synchronizer
  // -------------------------------------------------------------------------
  logic ack_meta_q;
  logic ack_s_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= DEV_ACK;
      ack_s_q    <= ack_meta_q;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q,  count_d;
  logic               overflow_q, overflow_d;

  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push_ok;
  logic               push_drop;
  logic [7:0]         head;

  state_t             state_q;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign head       = mem_q[rd_ptr_q];

  // A pop is the IDLE->SETUP launch; the FSM loads the head in the same edge.
  assign pop       = (state_q == S_IDLE) && ENABLE && !fifo_empty && !ack_s_q;

  // A full FIFO still accepts a byte when a slot is freed in the same cycle.
  assign push_ok   = TRANSFER_IN_RECEIVED && (!fifo_full || pop);
  assign push_drop = TRANSFER_IN_RECEIVED && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop     ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A new drop in the same cycle as CLEAR_ERR keeps the flag set.
    if (push_drop) begin
      overflow_d = 1'b1;
    end else if (CLEAR_ERR) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= TRANSFER_IN_BYTE;
    end
  end

  // -------------------------------------------------------------------------
  // Handshake FSM
  // -------------------------------------------------------------------------
  logic [CW-1:0] cnt_q;
  logic [7:0]    data_q;
  logic [7:0]    data_d;
  logic          strobe_q;
  logic          tmo_err_q;
  logic          strobe_tmo;
  logic          release_tmo;
  logic          release_done;

  assign strobe_tmo   = (state_q == S_STROBE)  && !ack_s_q && (cnt_q == TMO_LAST);
  assign release_tmo  = (state_q == S_RELEASE) &&  ack_s_q && (cnt_q == TMO_LAST);
  assign release_done = (state_q == S_RELEASE) && !ack_s_q;

  // The bus value is shared with the optional parity flop, so its next value
  // is formed once here rather than inside the FSM branches.
  always_comb begin
    if (pop) begin
      data_d = head;
    end else if (strobe_tmo || release_tmo || release_done) begin
      data_d = 8'h00;
    end else begin
      data_d = data_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      data_q    <= 8'h00;
      strobe_q  <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      data_q <= data_d;

      // Abort below overrides this clear when both happen together.
      if (CLEAR_ERR) begin
        tmo_err_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          strobe_q <= 1'b0;
          if (pop) begin
            cnt_q   <= '0;
            state_q <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            strobe_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_STROBE;
          end else begin
            strobe_q <= 1'b0;
            cnt_q    <= cnt_q + TICK_ONE;
          end
        end

        S_STROBE: begin
          if (ack_s_q) begin
            strobe_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_RELEASE;
          end else if (strobe_tmo) begin
            strobe_q  <= 1'b0;
            tmo_err_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            strobe_q <= 1'b1;
            cnt_q    <= cnt_q + TICK_ONE;
          end
        end

        S_RELEASE: begin
          strobe_q <= 1'b0;
          if (release_done) begin
            state_q <= S_IDLE;
          end else if (release_tmo) begin
            tmo_err_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + TICK_ONE;
          end
        end

        default: begin
          strobe_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

`ifdef HOST_SENDER_PARITY_EN
  // -------------------------------------------------------------------------
  // Optional parity, registered alongside DEV_DATA
  // -------------------------------------------------------------------------
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  logic parity_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      parity_q <= 1'b1;
    end else begin
      parity_q <= odd_parity(data_d);
    end
  end

  assign DEV_PARITY = parity_q;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign DEV_DATA    = data_q;
  assign DEV_STROBE  = strobe_q;
  assign FIFO_EMPTY  = fifo_empty;
  assign FIFO_FULL   = fifo_full;
  assign BUSY        = (state_q != S_IDLE);
  assign OVERFLOW    = overflow_q;
  assign TIMEOUT_ERR = tmo_err_q;

endmodule

// File: tb/tb_host_byte_sender.sv
// ---------------------------------------------------------------------------
// Testbench for host_byte_sender (TIMEOUT_CYCLES=16, SETUP_CYCLES=4, depth 4).
// Inputs change on the falling clock edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_host_byte_sender;

  logic       CLK;
  logic       RST;
  logic       TRANSFER_IN_RECEIVED;
  logic [7:0] TRANSFER_IN_BYTE;
  logic       ENABLE;
  logic       CLEAR_ERR;
  logic       DEV_ACK;
  logic [7:0] DEV_DATA;
  logic       DEV_STROBE;
`ifdef HOST_SENDER_PARITY_EN
  logic       DEV_PARITY;
`endif
  logic       FIFO_EMPTY;
  logic       FIFO_FULL;
  logic       BUSY;
  logic       OVERFLOW;
  logic       TIMEOUT_ERR;

  int n_cmp = 0;
  int n_bad = 0;

  host_byte_sender #(
    .FIFO_AW       (2),
    .SETUP_CYCLES  (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .TRANSFER_IN_RECEIVED(TRANSFER_IN_RECEIVED),
    .TRANSFER_IN_BYTE    (TRANSFER_IN_BYTE),
    .ENABLE              (ENABLE),
    .CLEAR_ERR           (CLEAR_ERR),
    .DEV_ACK             (DEV_ACK),
    .DEV_DATA            (DEV_DATA),
    .DEV_STROBE          (DEV_STROBE),
`ifdef HOST_SENDER_PARITY_EN
    .DEV_PARITY          (DEV_PARITY),
`endif
    .FIFO_EMPTY          (FIFO_EMPTY),
    .FIFO_FULL           (FIFO_FULL),
    .BUSY                (BUSY),
    .OVERFLOW            (OVERFLOW),
    .TIMEOUT_ERR         (TIMEOUT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One-cycle receive pulse; returns at the falling edge after the write edge.
  task automatic push(input logic [7:0] b);
    TRANSFER_IN_RECEIVED = 1'b1;
    TRANSFER_IN_BYTE     = b;
    @(negedge CLK);
    TRANSFER_IN_RECEIVED = 1'b0;
    TRANSFER_IN_BYTE     = 8'h00;
  endtask

  task automatic clear_err();
    CLEAR_ERR = 1'b1;
    @(negedge CLK);
    CLEAR_ERR = 1'b0;
  endtask

  // Plays the device side of one complete four-phase handshake.
  task automatic handshake(input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    while (!DEV_STROBE && n < 50) begin @(negedge CLK); n++; end
    chk({tag, "_strobe_up"}, DEV_STROBE, 1);
    chk({tag, "_data"}, DEV_DATA, exp);
    DEV_ACK = 1'b1;
    n = 0;
    while (DEV_STROBE && n < 50) begin @(negedge CLK); n++; end
    chk({tag, "_strobe_down"}, DEV_STROBE, 0);
    DEV_ACK = 1'b0;
    n = 0;
    while (BUSY && n < 50) begin @(negedge CLK); n++; end
    chk({tag, "_idle"}, BUSY, 0);
  endtask

  initial begin
    int n;
    RST                  = 1'b0;
    TRANSFER_IN_RECEIVED = 1'b0;
    TRANSFER_IN_BYTE     = 8'h00;
    ENABLE               = 1'b0;
    CLEAR_ERR            = 1'b0;
    DEV_ACK              = 1'b0;
    tick(2);

    // Reset state
    chk("rst_data",   DEV_DATA,    8'h00);
    chk("rst_strobe", DEV_STROBE,  0);
    chk("rst_empty",  FIFO_EMPTY,  1);
    chk("rst_full",   FIFO_FULL,   0);
    chk("rst_busy",   BUSY,        0);
    chk("rst_ovf",    OVERFLOW,    0);
    chk("rst_tmo",    TIMEOUT_ERR, 0);
`ifdef HOST_SENDER_PARITY_EN
    chk("rst_parity", DEV_PARITY,  1);
`endif
    RST = 1'b1;
    tick(2);

    // Single byte with exact latency
    ENABLE = 1'b1;
    push(8'hA5);                       // now just after edge t
    chk("sb_empty_after_push", FIFO_EMPTY, 0);
    chk("sb_data_before_pop", DEV_DATA, 8'h00);
    tick(1);                           // after t+1
    chk("sb_data_t1", DEV_DATA, 8'hA5);
    chk("sb_busy_t1", BUSY, 1);
    tick(3);                           // after t+4
    chk("sb_strobe_t4", DEV_STROBE, 0);
    tick(1);                           // after t+5
    chk("sb_strobe_t5", DEV_STROBE, 1);
    tick(9);
    DEV_ACK = 1'b1;                    // first sampled at edge E
    tick(2);                           // after E+1
    chk("sb_strobe_ack1", DEV_STROBE, 1);
    tick(1);                           // after E+2
    chk("sb_strobe_ack2", DEV_STROBE, 0);
    chk("sb_data_release", DEV_DATA, 8'hA5);
    chk("sb_busy_release", BUSY, 1);
    DEV_ACK = 1'b0;
    tick(3);
    chk("sb_data_done", DEV_DATA, 8'h00);
    chk("sb_busy_done", BUSY, 0);
    chk("sb_empty_done", FIFO_EMPTY, 1);

    // Burst fill and overflow
    ENABLE = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      TRANSFER_IN_RECEIVED = 1'b1;
      TRANSFER_IN_BYTE     = 8'(i);
      @(negedge CLK);
      if (i == 4) begin
        chk("burst_full4", FIFO_FULL, 1);
        chk("burst_ovf4", OVERFLOW, 0);
      end
    end
    TRANSFER_IN_RECEIVED = 1'b0;
    chk("burst_ovf5", OVERFLOW, 1);
    chk("burst_full5", FIFO_FULL, 1);
    clear_err();
    chk("burst_ovf_clr", OVERFLOW, 0);
    // Drop and clear in the same cycle: the drop wins
    CLEAR_ERR = 1'b1;
    push(8'h06);
    CLEAR_ERR = 1'b0;
    chk("burst_ovf_set_wins", OVERFLOW, 1);
    clear_err();
    chk("burst_ovf_clr2", OVERFLOW, 0);
    ENABLE = 1'b1;
    handshake(8'h01, "burst0");
    handshake(8'h02, "burst1");
    handshake(8'h03, "burst2");
    handshake(8'h04, "burst3");
    tick(4);
    chk("burst_empty_end", FIFO_EMPTY, 1);
    chk("burst_busy_end", BUSY, 0);

    // Timeout: strobe entry at edge t+5, abort at edge t+21
    push(8'h3C);
    tick(5);
    chk("tmo_strobe_on", DEV_STROBE, 1);
    tick(15);
    chk("tmo_still_waiting", DEV_STROBE, 1);
    chk("tmo_flag_before", TIMEOUT_ERR, 0);
    tick(1);
    chk("tmo_flag", TIMEOUT_ERR, 1);
    chk("tmo_strobe_off", DEV_STROBE, 0);
    chk("tmo_data_zero", DEV_DATA, 8'h00);
    chk("tmo_busy", BUSY, 0);
    tick(3);
    chk("tmo_no_retry", DEV_STROBE, 0);
    clear_err();
    chk("tmo_clear", TIMEOUT_ERR, 0);

    // Push accepted while full because IDLE pops in the same cycle
    ENABLE = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    chk("sim_full", FIFO_FULL, 1);
    ENABLE               = 1'b1;
    TRANSFER_IN_RECEIVED = 1'b1;
    TRANSFER_IN_BYTE     = 8'h77;
    @(negedge CLK);
    TRANSFER_IN_RECEIVED = 1'b0;
    chk("sim_ovf", OVERFLOW, 0);
    chk("sim_still_full", FIFO_FULL, 1);
    chk("sim_data", DEV_DATA, 8'h11);
    handshake(8'h11, "sim0");
    handshake(8'h22, "sim1");
    handshake(8'h33, "sim2");
    handshake(8'h44, "sim3");
    handshake(8'h77, "sim4");
    tick(2);
    chk("sim_empty_end", FIFO_EMPTY, 1);

    // ENABLE dropped mid-transfer: current handshake completes, no new pop
    ENABLE = 1'b0;
    push(8'hB1);
    push(8'hB2);
    ENABLE = 1'b1;
    n = 0;
    while (!DEV_STROBE && n < 50) begin @(negedge CLK); n++; end
    ENABLE = 1'b0;
    handshake(8'hB1, "en_mid");
    tick(10);
    chk("en_no_pop_busy", BUSY, 0);
    chk("en_no_pop_empty", FIFO_EMPTY, 0);
    ENABLE = 1'b1;
    handshake(8'hB2, "en_resume");

    // Ack already high in IDLE blocks a new transfer
    DEV_ACK = 1'b1;
    tick(3);
    push(8'hC3);
    tick(10);
    chk("ackhi_busy", BUSY, 0);
    chk("ackhi_empty", FIFO_EMPTY, 0);
    DEV_ACK = 1'b0;
    handshake(8'hC3, "ackhi");

    // Asynchronous reset mid-handshake with two bytes queued
    ENABLE = 1'b0;
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    ENABLE = 1'b1;
    n = 0;
    while (!DEV_STROBE && n < 50) begin @(negedge CLK); n++; end
    chk("mrst_in_strobe", DEV_STROBE, 1);
    RST = 1'b0;
    #1;
    chk("mrst_strobe", DEV_STROBE, 0);
    chk("mrst_data", DEV_DATA, 8'h00);
    chk("mrst_busy", BUSY, 0);
    chk("mrst_empty", FIFO_EMPTY, 1);
    chk("mrst_full", FIFO_FULL, 0);
`ifdef HOST_SENDER_PARITY_EN
    chk("mrst_parity", DEV_PARITY, 1);
`endif
    @(negedge CLK);
    RST = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (DEV_STROBE || BUSY) n++;
    end
    chk("mrst_no_activity", n, 0);
    push(8'h5A);
    handshake(8'h5A, "mrst_new");

`ifdef HOST_SENDER_PARITY_EN
    // Odd parity on the bus
    push(8'h07);
    tick(1);
    chk("par_07_data", DEV_DATA, 8'h07);
    chk("par_07", DEV_PARITY, 0);
    handshake(8'h07, "par07");
    push(8'h03);
    tick(1);
    chk("par_03", DEV_PARITY, 1);
    handshake(8'h03, "par03");
    chk("par_idle", DEV_PARITY, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/host_byte_sender.md
Name: host_byte_sender

Overview:
- Host-to-device counterpart of the device-to-host capture path.
- Receives bytes that the host writes through active_transfer (transfer_in_received / transfer_in_byte) and buffers them in a small FIFO.
- Presents each byte on a parallel bus to the external Arduino using a strobe/ack four-phase handshake, with timeout and error flags.
- Instantiated in the top level beside active_control_register, fed from the same transfer-in signals, driving spare J10 COMM pins.

Parameters:
- FIFO_AW, 2, log2 of FIFO depth (depth 4).
- SETUP_CYCLES, 4, cycles DEV_DATA is held stable before DEV_STROBE rises (1..15).
- TIMEOUT_CYCLES, 4095, maximum cycles spent waiting in STROBE or RELEASE before abort (12-bit).

Ports:
- CLK  in  1  system clock (66 MHz).
- RST  in  1  asynchronous active-low reset.
- TRANSFER_IN_RECEIVED  in  1  one-cycle pulse; TRANSFER_IN_BYTE is valid this cycle.
- TRANSFER_IN_BYTE  in  8  byte from host.
- ENABLE  in  1  1 = FSM may start new transfers (from control_register bit).
- CLEAR_ERR  in  1  one-cycle pulse; clears sticky flags.
- DEV_ACK  in  1  asynchronous ack from device.
- DEV_DATA  out  8  byte to device.
- DEV_STROBE  out  1  data-valid strobe to device.
- FIFO_EMPTY  out  1  FIFO count == 0.
- FIFO_FULL  out  1  FIFO count == 2^FIFO_AW.
- BUSY  out  1  FSM not in IDLE.
- OVERFLOW  out  1  sticky: a byte was dropped because the FIFO was full.
- TIMEOUT_ERR  out  1  sticky: a handshake aborted.

Behaviour:
- Reset values:
  - DEV_DATA=0, DEV_STROBE=0, BUSY=0, OVERFLOW=0, TIMEOUT_ERR=0.
  - FIFO_EMPTY=1, FIFO_FULL=0; FIFO pointers and count 0; FSM in IDLE.
  - ACK synchronizer flops 0.
- DEV_ACK passes through a 2-flop synchronizer (ack_s); the FSM uses only ack_s.
- FIFO:
  - Registered write on TRANSFER_IN_RECEIVED; pointers wrap modulo depth; count is FIFO_AW+1 bits.
  - Push while full with no pop in the same cycle: byte dropped, OVERFLOW set, count unchanged.
  - Push while full with a simultaneous pop: push accepted, count unchanged.
  - Simultaneous push and pop when not full: count unchanged.
- FSM states: IDLE, SETUP, STROBE, RELEASE.
  - IDLE: if ENABLE && !FIFO_EMPTY && !ack_s, pop the head into DEV_DATA, clear cnt, go to SETUP.
  - SETUP: DEV_STROBE=0; cnt increments; at cnt==SETUP_CYCLES-1, set DEV_STROBE=1, clear cnt, go to STROBE.
  - STROBE: DEV_STROBE=1; if ack_s, DEV_STROBE=0, clear cnt, go to RELEASE. Otherwise, at cnt==TIMEOUT_CYCLES-1, abort.
  - RELEASE: DEV_STROBE=0, DEV_DATA held; if !ack_s, DEV_DATA=0, go to IDLE. Otherwise, at cnt==TIMEOUT_CYCLES-1, abort.
  - Abort: TIMEOUT_ERR=1, DEV_STROBE=0, DEV_DATA=0, go to IDLE; the byte is discarded, not retried.
- Latency: receive pulse at edge t, then DEV_DATA valid after edge t+1, then DEV_STROBE rises after edge t+1+SETUP_CYCLES.
- ENABLE deassertion mid-transfer: the current handshake completes; no new pop occurs.
- ack_s already high in IDLE: no transfer starts until it falls.
- CLEAR_ERR clears OVERFLOW and TIMEOUT_ERR. If CLEAR_ERR and a new error event occur in the same cycle, set wins.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronously); FIFO contents are lost.
- BUSY = (state != IDLE).

Optional Feature:
- Macro: HOST_SENDER_PARITY_EN.
- Defined: adds output port DEV_PARITY (1 bit), registered with DEV_DATA, equal to the odd parity of DEV_DATA (XNOR of its bits). DEV_PARITY=1 whenever DEV_DATA=0 (including reset and after RELEASE/abort).
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Single byte: ENABLE=1, push 0xA5 at t.
  - DEV_DATA=0xA5 after t+1; DEV_STROBE rises after t+5 (SETUP_CYCLES=4).
  - Device acks after 10 cycles: STROBE falls 2 cycles after the DEV_ACK edge.
  - Drop DEV_ACK: DEV_DATA returns to 0 and BUSY=0 within 3 cycles.
- Burst and overflow: ENABLE=0, push 0x01..0x05 back-to-back.
  - FIFO_FULL=1 after the 4th push; OVERFLOW=1 after the 5th.
  - ENABLE=1 with an auto-ack device: device sees 0x01,0x02,0x03,0x04 in order; FIFO_EMPTY=1 at end.
- Timeout: TIMEOUT_CYCLES=16, push 0x3C, DEV_ACK held 0.
  - TIMEOUT_ERR=1, DEV_STROBE=0 and DEV_DATA=0 at 16 cycles after STROBE entry.
  - CLEAR_ERR pulse: TIMEOUT_ERR=0.
- Simultaneous push/pop when full: fill 4 bytes, ENABLE=1; push 0x77 in the cycle IDLE pops.
  - OVERFLOW stays 0; 0x77 is transferred 5th.
- Reset mid-handshake: assert RST low while in STROBE with 2 bytes queued.
  - All outputs at reset values immediately.
  - After release, no strobe occurs until a new push.
- Parity (HOST_SENDER_PARITY_EN defined): push 0x07, then DEV_PARITY=0; push 0x03, then DEV_PARITY=1.
